// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready stage register, two-entry skid (SKID=1) or single entry (SKID=0).
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_buf #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 96,
    parameter int RD_W   = 5,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic [RD_W-1:0]   out_rd,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`else
    output logic [RD_W-1:0]   out_rd
`endif
);
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [RD_W-1:0]   skid_rd;
    logic              skid_valid, accept, emit;

    // With SKID=0 the skid entry is never filled: in_ready drops whenever main is stuck.
    assign in_ready = SKID ? ~skid_valid : (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign emit     = out_valid & out_ready;
    assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            out_data   <= '0;
            out_rd     <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            skid_rd    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (~out_valid | emit) begin
            out_valid  <= skid_valid | accept;
            skid_valid <= 1'b0;
            if (skid_valid) begin
                main_ctrl <= skid_ctrl;
                out_data  <= skid_data;
                out_rd    <= skid_rd;
            end else if (accept) begin
                main_ctrl <= in_ctrl;
                out_data  <= in_data;
                out_rd    <= in_rd;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            skid_rd    <= in_rd;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
            if (~out_valid & ~&bubble_cnt) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed table plus randomized traffic against a queue model, SKID=1 and SKID=0 side by side.
module tb_pipe_stage_buf;
    localparam int CW = 2;
    localparam int DW = 96;
    localparam int RW = 5;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic [RW-1:0] rd;
    } beat_t;

    typedef struct packed {
        logic          iv;
        logic          ordy;
        logic          fl;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic          ev;
        logic [CW-1:0] ectrl;
        logic [DW-1:0] edata;
        logic          erdy;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic [RW-1:0] in_rd = '0;

    logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [CW-1:0] a_ctrl, b_ctrl;
    logic [DW-1:0] a_data, b_data;
    logic [RW-1:0] a_rd, b_rd;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] a_stall, a_bubble, b_stall, b_bubble;
    logic [31:0] ma_stall = 0, ma_bubble = 0, mb_stall = 0, mb_bubble = 0;
`endif

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .SKID(1'b1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_ctrl), .out_data(a_data),
`ifdef PIPE_STAGE_PERF_EN
        .out_rd(a_rd), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
`else
        .out_rd(a_rd)
`endif
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .SKID(1'b0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_ctrl), .out_data(b_data),
`ifdef PIPE_STAGE_PERF_EN
        .out_rd(b_rd), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
`else
        .out_rd(b_rd)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic beat_t shown(input beat_t q[$], input beat_t last);
        if (q.size() > 0) return q[0];
        return last;
    endfunction

    // Reference: each stage is a FIFO of held beats; capacity 2 (skid) or 1 with pass-through.
    beat_t qa[$], qb[$];
    beat_t la = '0, lb = '0;

    always @(posedge clk or posedge reset) begin
        beat_t ib;
        bit ra, rb;
        if (reset) begin
            qa.delete();
            qb.delete();
            la = '0;
            lb = '0;
`ifdef PIPE_STAGE_PERF_EN
            ma_stall = 0; ma_bubble = 0; mb_stall = 0; mb_bubble = 0;
`endif
        end else begin
            ib = {in_ctrl, in_data, in_rd};
            ra = qa.size() < 2;
            rb = qb.size() == 0 || out_ready;
`ifdef PIPE_STAGE_PERF_EN
            if (qa.size() > 0 && !out_ready && ma_stall != '1) ma_stall++;
            if (qa.size() == 0 && ma_bubble != '1) ma_bubble++;
            if (qb.size() > 0 && !out_ready && mb_stall != '1) mb_stall++;
            if (qb.size() == 0 && mb_bubble != '1) mb_bubble++;
`endif
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (qa.size() > 0 && out_ready) void'(qa.pop_front());
                if (in_valid && ra) qa.push_back(ib);
                if (qb.size() > 0 && out_ready) void'(qb.pop_front());
                if (in_valid && rb) qb.push_back(ib);
            end
            if (qa.size() > 0) la = qa[0];
            if (qb.size() > 0) lb = qb[0];
        end
    end

    always @(negedge clk) begin
        beat_t ea, eb;
        ea = shown(qa, la);
        eb = shown(qb, lb);
        check("a_valid", a_out_valid, qa.size() > 0);
        check("a_ctrl", a_ctrl, qa.size() > 0 ? ea.ctrl : '0);
        check("a_data", a_data, ea.data);
        check("a_rd", a_rd, ea.rd);
        check("a_in_ready", a_in_ready, qa.size() < 2);
        check("b_valid", b_out_valid, qb.size() > 0);
        check("b_ctrl", b_ctrl, qb.size() > 0 ? eb.ctrl : '0);
        check("b_data", b_data, eb.data);
        check("b_rd", b_rd, eb.rd);
        check("b_in_ready", b_in_ready, qb.size() == 0 || out_ready);
`ifdef PIPE_STAGE_PERF_EN
        check("a_stall_cnt", a_stall, ma_stall);
        check("a_bubble_cnt", a_bubble, ma_bubble);
        check("b_stall_cnt", b_stall, mb_stall);
        check("b_bubble_cnt", b_bubble, mb_bubble);
`endif
    end

    initial begin
        vec_t tbl[12];
        // Stall with A,B,C then drain; fill and flush; flush discarding an accepted beat.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd1, 96'hA,  1'b1, 2'd1, 96'hA,  1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd2, 96'hB,  1'b1, 2'd1, 96'hA,  1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd3, 96'hC,  1'b1, 2'd1, 96'hA,  1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'd3, 96'hC,  1'b1, 2'd2, 96'hB,  1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'd3, 96'hC,  1'b1, 2'd3, 96'hC,  1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 96'h0,  1'b0, 2'd0, 96'hC,  1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd1, 96'hD1, 1'b1, 2'd1, 96'hD1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd2, 96'hD2, 1'b1, 2'd1, 96'hD1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'd3, 96'hD3, 1'b0, 2'd0, 96'hD1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 96'h0,  1'b0, 2'd0, 96'hD1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 2'd1, 96'hE,  1'b0, 2'd0, 96'hD1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 96'h0,  1'b0, 2'd0, 96'hD1, 1'b1};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; flush = tbl[i].fl;
            in_ctrl = tbl[i].ctrl; in_data = tbl[i].data; in_rd = tbl[i].data[RW-1:0];
            @(posedge clk); #1;
            check($sformatf("tbl%0d_valid", i), a_out_valid, tbl[i].ev);
            check($sformatf("tbl%0d_ctrl", i), a_ctrl, tbl[i].ectrl);
            check($sformatf("tbl%0d_data", i), a_data, tbl[i].edata);
            check($sformatf("tbl%0d_in_ready", i), a_in_ready, tbl[i].erdy);
        end
        flush = 1'b0;

        // Back-to-back beats 1..8 with out_ready held high: no gaps on the skid stage.
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 2'd1; in_data = DW'(k); in_rd = RW'(k);
            @(posedge clk); #1;
            check($sformatf("stream%0d_valid", k), a_out_valid, 1'b1);
            check($sformatf("stream%0d_data", k), a_data, 128'(k));
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Alternating out_ready with continuous input: single-entry stage checked by the model.
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1; out_ready = k[0]; in_ctrl = 2'(k); in_data = DW'(32'h100 + k); in_rd = RW'(k);
            @(posedge clk); #1;
        end

        // Fill the skid stage while stalled, then reset mid-cycle.
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_async_valid", a_out_valid, 1'b0);
        check("rst_async_ctrl", a_ctrl, 2'd0);
        check("rst_async_in_ready", a_in_ready, 1'b1);
        check("rst_async_b_valid", b_out_valid, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        in_valid = 1'b1; in_ctrl = 2'b11; in_rd = 5'd5; in_data = 96'h55;
        @(posedge clk); #1;
        check("post_rst_valid", a_out_valid, 1'b1);
        check("post_rst_ctrl", a_ctrl, 2'b11);
        check("post_rst_rd", a_rd, 5'd5);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 3000; k++) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 31) == 0;
            in_ctrl = CW'($urandom);
            in_data = {$urandom, $urandom, $urandom};
            in_rd = RW'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline-stage register for the 5-stage core, replacing the fixed per-stage registers (EX/MEM, MEM/WB, ...).
- Carries a control bundle, a data bundle and a destination register index between stages under valid/ready handshake, with stall back-pressure and synchronous flush.
- Mode parameter selects full-throughput skid buffer (2 entries) or single-entry register; bubbles always present all-zero control so no spurious RegWrite/MemWrite.

Parameters:
- CTRL_W, 2, width of control bundle (e.g. {RegWrite, MemtoReg}).
- DATA_W, 96, width of data bundle (e.g. {mem_data, alu_result, pc_plus4}).
- RD_W, 5, destination register index width.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream data bundle
- in_rd  input  RD_W  upstream destination index
- out_valid  output  1  downstream beat valid
- out_ready  input  1  downstream accepts beat
- out_ctrl  output  CTRL_W  control bundle; forced 0 when out_valid=0
- out_data  output  DATA_W  data bundle
- out_rd  output  RD_W  destination index

Behaviour:
- Reset (async, active-high) is decided: reset reset, asynchronous, active-high; clock clk.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, out_rd=0, skid entry invalid, in_ready=1.
- Accept = in_valid & in_ready; emit = out_valid & out_ready, both sampled at the rising edge.
- Latency: an accepted beat appears on outputs the next cycle when the stage is empty.
- While out_valid=1 & out_ready=0, out_ctrl/out_data/out_rd hold stable.
- Beats leave in acceptance order; no duplication, no loss except on flush.
- SKID=1:
  - States are EMPTY (main invalid), ONE (main valid, skid invalid) and FULL (both valid).
  - EMPTY + accept -> ONE.
  - ONE + accept + emit -> ONE, new beat loaded into main.
  - ONE + accept + no emit -> FULL, beat stored in skid.
  - ONE + emit + no accept -> EMPTY.
  - FULL + emit -> ONE, main <= skid.
  - in_ready is registered: in_ready = ~skid_valid. Full throughput (1 beat/cycle) with out_ready held 1.
- SKID=0:
  - Single entry; in_ready = ~out_valid | out_ready (combinational path from out_ready).
  - Accept + emit in same cycle replaces the entry.
- Data regs of invalid entries: don't-care internally, but out_data/out_rd keep last value when out_valid=0 (no toggling on bubbles).
- flush:
  - Highest priority after reset: next cycle out_valid=0, skid invalid, in_ready=1.
  - Any beat accepted in the flush cycle is discarded.
  - An emit in the flush cycle counts as transferred.
- out_ctrl = held_ctrl & {CTRL_W{out_valid}}.
- Reset mid-stall: all entries drop immediately; in_ready returns 1 asynchronously.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle out_valid=1 & out_ready=0.
  - bubble_cnt increments each cycle out_valid=0.
  - Both saturate at 0xFFFFFFFF and clear on reset (not on flush).
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset during FULL state with out_ready=0 -> out_valid=0, out_ctrl=0, in_ready=1 immediately; after release, first beat (ctrl=2'b11, rd=5) appears 1 cycle after accept.
- SKID=1, in_valid=1 every cycle, out_ready=1, beats data=1..8 -> out_data=1..8 on 8 consecutive cycles, no gaps.
- SKID=1, out_ready=0 for 3 cycles while sending beats A,B,C -> A held on output, B in skid, in_ready=0 from cycle after B; out_ready=1 -> A, B, C emitted in order.
- flush asserted with both entries full and in_valid=1 (beat D) -> next cycle out_valid=0, out_ctrl=0; D never emitted.
- SKID=0, alternating out_ready 1/0 with continuous in_valid -> in_ready tracks ~out_valid|out_ready combinationally; order preserved, no beat lost.
- PIPE_STAGE_PERF_EN: 5 stalled cycles then 3 empty cycles -> stall_cnt=5, bubble_cnt=3 (plus post-reset idle cycles counted).
